shift_arbiter: RTL and testbench

//  Shares one barrel-shift datapath (shift/rotate, left/right) between NREQ requesters.
//  - Arbitrates among pending requests and captures the winner's operands.
//  - Runs the shared shifter and returns the result, tagged with the requester index,
//    on a single valid/ready response channel.
//  - Sits between the client pipelines and the common shift unit.

---
 rtl/shift_arbiter_pkg.sv | 30 +++
 rtl/shift_core.sv | 28 ++
 rtl/shift_arbiter.sv | 151 +++++++++++++++
 tb/tb_shift_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift arbiter: operation encodings, FSM state
// encodings and the derived-width helpers used by the top and by shift_core.
package shift_arbiter_pkg;

    // Operation encodings carried on req_type
    typedef enum logic [1:0] {
        SH_LL = 2'b00,   // shift left, zero fill
        SH_LR = 2'b01,   // shift right (logical), zero fill
        SH_RL = 2'b10,   // rotate left
        SH_RR = 2'b11    // rotate right
    } shift_type_t;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Shift-amount width for a W-bit datapath (at least one bit)
    function automatic int shift_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // Requester-index width for NREQ requesters (at least one bit)
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shift_core.sv
// Purely combinational W-bit shift/rotate unit shared by all requesters.
// Rotates use a doubled operand so that a rotate by zero is the operand itself
// and never mixes in a full W-bit shift.
module shift_core
    import shift_arbiter_pkg::*;
#(
    parameter  int W  = 8,
    localparam int SW = shift_width(W)
) (
    input  logic [W-1:0]  data,
    input  logic [SW-1:0] shift,
    input  shift_type_t   kind,
    output logic [W-1:0]  result
);

    // Select the operation; shifts zero-fill, rotates wrap modulo W
    always_comb begin
        result = data;
        case (kind)
            SH_LL:   result = data << shift;
            SH_LR:   result = data >> shift;
            SH_RL:   result = W'(({data, data} << shift) >> W);
            SH_RR:   result = W'({data, data} >> shift);
            default: result = data;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one shift_core between NREQ requesters.
// IDLE grants one pending requester (req_ready is a same-cycle one-hot strobe)
// and captures its operands; EXEC registers the core result; RESP holds the
// tagged result on a valid/ready channel until accepted.
// Handshake: a response transfers on a rising edge where resp_valid and
// resp_ready are both high; resp_data/resp_id are stable while resp_valid is
// high and not yet accepted.
// Build option: define SHIFT_ARB_RR_EN for round-robin arbitration (search
// starts at a pointer that moves past each winner); otherwise fixed priority,
// lowest index wins, and no pointer register exists.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter  int W    = 8,
    parameter  int NREQ = 4,
    localparam int SW   = shift_width(W),
    localparam int IDW  = id_width(NREQ)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_data,
    input  logic [NREQ*SW-1:0] req_shift,
    input  logic [NREQ*2-1:0] req_type,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [W-1:0]      resp_data,
    output logic [IDW-1:0]    resp_id,
    output logic              busy
);

    state_t          state;

    // Registered copy of the winner's request
    logic [W-1:0]    op_data;
    logic [SW-1:0]   op_shift;
    shift_type_t     op_kind;
    logic [IDW-1:0]  op_id;

    // Arbitration results for the current cycle
    logic            grant_any;
    logic [IDW-1:0]  grant_idx;
    logic [NREQ-1:0] grant_vec;
    logic [W-1:0]    sel_data;
    logic [SW-1:0]   sel_shift;
    shift_type_t     sel_kind;

    logic [W-1:0]    core_result;

`ifdef SHIFT_ARB_RR_EN
    logic [IDW-1:0]  rr_ptr;
`endif

    // Pick the winner: scan from the search start, the closest pending index wins
    always_comb begin
        int start;
        int cand;
        grant_any = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        sel_data  = '0;
        sel_shift = '0;
        sel_kind  = SH_LL;
`ifdef SHIFT_ARB_RR_EN
        start = int'(rr_ptr);
`else
        start = 0;
`endif
        cand = 0;
        // Descending scan so the last hit (smallest offset) takes precedence
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = start + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (req_valid[cand]) begin
                grant_any       = 1'b1;
                grant_idx       = IDW'(cand);
                grant_vec       = '0;
                grant_vec[cand] = 1'b1;
                sel_data        = req_data[cand*W +: W];
                sel_shift       = req_shift[cand*SW +: SW];
                sel_kind        = shift_type_t'(req_type[cand*2 +: 2]);
            end
        end
    end

    // Grant strobe only in IDLE, and forced low while reset is asserted
    assign req_ready = (reset_n && (state == ST_IDLE)) ? grant_vec : '0;
    assign busy      = (state != ST_IDLE);

    // The single shared shifter, fed only from the captured operands
    shift_core #(
        .W (W)
    ) u_core (
        .data   (op_data),
        .shift  (op_shift),
        .kind   (op_kind),
        .result (core_result)
    );

    // Control FSM with operand capture, result register and arbitration pointer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            op_data    <= '0;
            op_shift   <= '0;
            op_kind    <= SH_LL;
            op_id      <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
`ifdef SHIFT_ARB_RR_EN
            rr_ptr     <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        op_data  <= sel_data;
                        op_shift <= sel_shift;
                        op_kind  <= sel_kind;
                        op_id    <= grant_idx;
                        state    <= ST_EXEC;
`ifdef SHIFT_ARB_RR_EN
                        rr_ptr   <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
`endif
                    end
                end
                ST_EXEC: begin
                    resp_data  <= core_result;
                    resp_id    <= op_id;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter (W=8, NREQ=4): directed scenarios followed by
// randomized operations, checked against an arithmetic reference model.
// Honors SHIFT_ARB_RR_EN the same way the design does.
module tb_shift_arbiter;

    localparam int W    = 8;
    localparam int NREQ = 4;
    localparam int SW   = 3;
    localparam int IDW  = 2;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_data = '0;
    logic [NREQ*SW-1:0] req_shift = '0;
    logic [NREQ*2-1:0] req_type = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [W-1:0]      resp_data;
    logic [IDW-1:0]    resp_id;
    logic              busy;

    shift_arbiter #(.W(W), .NREQ(NREQ)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_shift  (req_shift),
        .req_type   (req_type),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];
    int           id_q[$];

    int op_d[NREQ];
    int op_s[NREQ];
    int op_t[NREQ];
    int rr_ptr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_shift(input int d, input int s, input int t);
        int m;
        m = 1 << W;
        case (t)
            0:       return (d * (1 << s)) % m;
            1:       return d / (1 << s);
            2:       return ((d * (1 << s)) % m) + d / (1 << (W - s));
            default: return d / (1 << s) + (d * (1 << (W - s))) % m;
        endcase
    endfunction

    function automatic int pick(input logic [NREQ-1:0] mask);
        int start;
`ifdef SHIFT_ARB_RR_EN
        start = rr_ptr;
`else
        start = 0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            if (mask[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*W +: W]   = W'(op_d[i]);
            req_shift[i*SW +: SW] = SW'(op_s[i]);
            req_type[i*2 +: 2]   = 2'(op_t[i]);
        end
    endtask

    task automatic set_op(input int i, input int d, input int s, input int t);
        op_d[i] = d;
        op_s[i] = s;
        op_t[i] = t;
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < NREQ; i++) begin
            set_op(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end
    endtask

    // One full operation, entered and left at a falling edge with the DUT idle.
    // hold: cycles resp_ready stays low in RESP; scramble: change/drop the
    // requests while the captured operation executes.
    task automatic run_op(input logic [NREQ-1:0] mask, input int hold, input bit scramble);
        int g;
        int exp_id;
        logic [W-1:0] exp_d;
        req_valid  = mask;
        resp_ready = (hold == 0);
        drive_ops();
        #1;
        g = pick(mask);
        check("grant", 32'(req_ready), 32'(1) << g);
        check("busy_idle", 32'(busy), 32'd0);
        exp_q.push_back(W'(ref_shift(op_d[g], op_s[g], op_t[g])));
        id_q.push_back(g);
`ifdef SHIFT_ARB_RR_EN
        rr_ptr = (g + 1) % NREQ;
`endif
        @(negedge clock);
        if (scramble) begin
            randomize_ops();
            drive_ops();
            req_valid = NREQ'($urandom_range(0, 15)) & mask;
        end
        #1;
        check("ready_exec", 32'(req_ready), 32'd0);
        check("valid_exec", 32'(resp_valid), 32'd0);
        check("busy_exec", 32'(busy), 32'd1);
        @(negedge clock);
        exp_d  = exp_q.pop_front();
        exp_id = id_q.pop_front();
        for (int c = 0; c <= hold; c++) begin
            resp_ready = (c == hold);
            #1;
            check("resp_valid", 32'(resp_valid), 32'd1);
            check("resp_data", 32'(resp_data), 32'(exp_d));
            check("resp_id", 32'(resp_id), 32'(exp_id));
            check("ready_resp", 32'(req_ready), 32'd0);
            check("busy_resp", 32'(busy), 32'd1);
            @(negedge clock);
        end
        req_valid  = '0;
        resp_ready = 1'($urandom_range(0, 1));
        #1;
        check("valid_drop", 32'(resp_valid), 32'd0);
        check("busy_drop", 32'(busy), 32'd0);
        @(negedge clock);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int g;
        for (int i = 0; i < NREQ; i++) set_op(i, 0, 0, 0);

        // Reset: outputs all zero even with every requester pending
        req_valid = '1;
        randomize_ops();
        drive_ops();
        @(negedge clock);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_data", 32'(resp_data), 32'd0);
        check("rst_id", 32'(resp_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clock);
        req_valid = '0;
        reset_n   = 1'b1;
        rr_ptr    = 0;
        @(negedge clock);

        // All four pending, resp_ready high: RR 0,1,2,3,0 / fixed 0 each time
        randomize_ops();
        for (int n = 0; n < 5; n++) run_op(4'b1111, 0, 1'b0);

        // Requester 2 alone: 8'hB4 rotl 3
        set_op(2, 8'hB4, 3, 2);
        run_op(4'b0100, 0, 1'b0);

        // Requester 1: 8'h81 shifted by 0 under every type, then shr/shl by 7
        for (int t = 0; t < 4; t++) begin
            set_op(1, 8'h81, 0, t);
            run_op(4'b0010, 0, 1'b0);
        end
        set_op(1, 8'h81, 7, 1);
        run_op(4'b0010, 0, 1'b0);
        set_op(1, 8'h81, 7, 0);
        run_op(4'b0010, 0, 1'b0);

        // Backpressure: five cycles with resp_ready low, others still requesting
        randomize_ops();
        run_op(4'b1011, 5, 1'b0);

        // Requester 3: 8'h0F rotr 4, request dropped and operands changed in EXEC
        set_op(3, 8'h0F, 4, 3);
        run_op(4'b1000, 0, 1'b1);

        // Reset during EXEC aborts the operation
        randomize_ops();
        req_valid  = 4'b0001;
        resp_ready = 1'b1;
        drive_ops();
        #1;
        g = pick(4'b0001);
        check("abort_grant", 32'(req_ready), 32'(1) << g);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("abort_valid", 32'(resp_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd0);
        check("abort_data", 32'(resp_data), 32'd0);
        check("abort_id", 32'(resp_id), 32'd0);
        rr_ptr = 0;
        @(negedge clock);
        req_valid = '0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            #1;
            check("post_abort_valid", 32'(resp_valid), 32'd0);
            check("post_abort_busy", 32'(busy), 32'd0);
        end
        @(negedge clock);
        set_op(0, 8'h3C, 2, 0);
        run_op(4'b0001, 0, 1'b0);

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            randomize_ops();
            run_op(NREQ'($urandom_range(1, 15)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
